// File: rtl/tdc_frame_rx_if.sv
// Serial line in, decoded byte/frame results out, for the TDC frame receiver.
// The master side drives the line; the slave side is the receiver itself.
interface tdc_frame_rx_if #(
    parameter int unsigned N_BYTES = 2
);
    localparam int unsigned FRAME_W = 8 * N_BYTES;

    logic               rx_in;
    logic [7:0]         byte_data;
    logic               byte_valid;
    logic [FRAME_W-1:0] frame_data;
    logic               frame_valid;
    logic               frame_err;
    logic               busy;

    modport master (
        output rx_in,
        input  byte_data, byte_valid, frame_data, frame_valid, frame_err, busy
    );

    modport slave (
        input  rx_in,
        output byte_data, byte_valid, frame_data, frame_valid, frame_err, busy
    );
endinterface

// File: rtl/tdc_frame_rx.sv
// 8N1 UART receiver plus frame assembler for the TDC serial link: packs N_BYTES
// bytes (MS byte first) into one word, flags bad stop bits and stalled frames.
module tdc_frame_rx #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned N_BYTES      = 2,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    tdc_frame_rx_if.slave rx_if
);
    localparam int unsigned BIT_W     = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
    localparam int unsigned TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TMO_W     = $clog2(TMO_LIMIT + 1);
    localparam int unsigned CNT_W     = $clog2(N_BYTES + 1);
    localparam int unsigned FRAME_W   = 8 * N_BYTES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t             state;
    logic               rx_m, rx_s, rx_d;
    logic [BIT_W-1:0]   bit_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;
    logic [FRAME_W-1:0] acc;
    logic [CNT_W-1:0]   count;
    logic [TMO_W-1:0]   tmo_cnt;

    logic [7:0]         byte_data;
    logic               byte_valid;
    logic [FRAME_W-1:0] frame_data;
    logic               frame_valid;
    logic               frame_err;

    logic               start_edge_c;
    logic               half_done_c;
    logic               bit_done_c;
    logic               last_byte_c;
    logic               tmo_hit_c;
    logic [FRAME_W-1:0] frame_next_c;

    // Two-flop synchroniser plus one delayed copy for start-edge detection; idle line is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx_if.rx_in;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign start_edge_c = rx_d & ~rx_s;
    assign half_done_c  = (bit_cnt == BIT_W'(HALF_BIT - 1));
    assign bit_done_c   = (bit_cnt == BIT_W'(CLKS_PER_BIT - 1));
    assign last_byte_c  = (count == CNT_W'(N_BYTES - 1));
    assign tmo_hit_c    = (tmo_cnt == TMO_W'(TMO_LIMIT - 1));
    // Accumulator shifted up one byte with the new byte in the LS position.
    assign frame_next_c = FRAME_W'({acc, shift});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            acc         <= '0;
            count       <= '0;
            tmo_cnt     <= '0;
            byte_data   <= '0;
            byte_valid  <= 1'b0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;

            case (state)
                S_IDLE: begin
                    // Inter-byte stall detector; it wins over a start edge in the same cycle.
                    if (count != '0) begin
                        if (tmo_hit_c) begin
                            frame_err <= 1'b1;
                            count     <= '0;
                            acc       <= '0;
                            tmo_cnt   <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    if (start_edge_c) begin
                        state   <= S_START;
                        bit_cnt <= '0;
                    end
                end

                S_START: begin
                    if (half_done_c) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (bit_done_c) begin
                        bit_cnt <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (bit_done_c) begin
                        bit_cnt <= '0;
                        if (rx_s) begin
                            state      <= S_IDLE;
                            byte_data  <= shift;
                            byte_valid <= 1'b1;
                            tmo_cnt    <= '0;
                            if (last_byte_c) begin
                                frame_data  <= frame_next_c;
                                frame_valid <= 1'b1;
                                count       <= '0;
                                acc         <= '0;
                            end else begin
                                acc   <= frame_next_c;
                                count <= count + 1'b1;
                            end
                        end else begin
                            state     <= S_BREAK;
                            frame_err <= 1'b1;
                            count     <= '0;
                            acc       <= '0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                // Held-low line after a framing error must go high before a new start is honoured.
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign rx_if.byte_data   = byte_data;
    assign rx_if.byte_valid  = byte_valid;
    assign rx_if.frame_data  = frame_data;
    assign rx_if.frame_valid = frame_valid;
    assign rx_if.frame_err   = frame_err;
    assign rx_if.busy        = (state != S_IDLE) | (count != '0);

endmodule

// File: tb/tb_tdc_frame_rx.sv
// Bench for tdc_frame_rx: directed cases plus random byte traffic, checked against
// a byte/frame-level model of the receiver.
module tb_tdc_frame_rx;
    localparam int unsigned CPB     = 8;
    localparam int unsigned NB      = 2;
    localparam int unsigned TOB     = 20;
    localparam int unsigned FW      = 8 * NB;
    localparam int unsigned TMO_CYC = CPB * TOB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tdc_frame_rx_if #(.N_BYTES(NB)) bus ();

    tdc_frame_rx #(
        .CLKS_PER_BIT(CPB),
        .N_BYTES     (NB),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rx_if(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed pulses
    logic [7:0]    got_bytes[$];
    logic [FW-1:0] got_frames[$];
    int            got_errs = 0;
    int            cyc      = 0;
    int            bv_cyc   = 0;
    int            fe_cyc   = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.byte_valid) begin
                got_bytes.push_back(bus.byte_data);
                bv_cyc = cyc;
            end
            if (bus.frame_valid) got_frames.push_back(bus.frame_data);
            if (bus.frame_err) begin
                got_errs++;
                fe_cyc = cyc;
            end
            if (bus.frame_valid || bus.frame_err)
                check("fv_fe_excl", {31'b0, bus.frame_valid & bus.frame_err}, 32'd0);
        end
    end

    // Reference model: bytes in, expected bytes/frames/errors out
    logic [7:0]    exp_bytes[$];
    logic [FW-1:0] exp_frames[$];
    int            exp_errs = 0;
    int            m_cnt    = 0;
    logic [31:0]   m_acc    = '0;

    function automatic void model_good(input logic [7:0] b);
        exp_bytes.push_back(b);
        m_acc = (m_acc << 8) | 32'(b);
        m_cnt++;
        if (m_cnt == NB) begin
            exp_frames.push_back(FW'(m_acc));
            m_cnt = 0;
            m_acc = '0;
        end
    endfunction

    function automatic void model_bad();
        exp_errs++;
        m_cnt = 0;
        m_acc = '0;
    endfunction

    function automatic void model_long_idle();
        if (m_cnt > 0) begin
            exp_errs++;
            m_cnt = 0;
            m_acc = '0;
        end
    endfunction

    function automatic void model_reset();
        m_cnt = 0;
        m_acc = '0;
    endfunction

    task automatic check_segment(input string tag);
        check({tag, "_nbytes"}, got_bytes.size(), exp_bytes.size());
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
            check({tag, "_byte"}, got_bytes[i], exp_bytes[i]);
        check({tag, "_nframes"}, got_frames.size(), exp_frames.size());
        for (int i = 0; i < got_frames.size() && i < exp_frames.size(); i++)
            check({tag, "_frame"}, got_frames[i], exp_frames[i]);
        check({tag, "_nerrs"}, got_errs, exp_errs);
        got_bytes.delete();
        exp_bytes.delete();
        got_frames.delete();
        exp_frames.delete();
        got_errs = 0;
        exp_errs = 0;
    endtask

    task automatic idle(input int n);
        bus.rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_long(input int n);
        idle(n);
        model_long_idle();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bus.rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.rx_in = stop;
        repeat (CPB) @(negedge clk);
        bus.rx_in = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b);
        send_byte(b, 1'b1);
        model_good(b);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] part;
        int         k;

        bus.rx_in = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;

        // Idle line after reset
        idle(500);
        check("t1_byte_data", bus.byte_data, 32'h0);
        check("t1_frame_data", bus.frame_data, 32'h0);
        check("t1_busy", bus.busy, 32'd0);
        check_segment("t1");

        // Single byte leaves a partial frame pending
        send_good(8'hA5);
        idle(20);
        check("t2_byte_data", bus.byte_data, 32'hA5);
        check("t2_busy", bus.busy, 32'd1);
        check_segment("t2");
        idle_long(300);
        check("t2_busy_after_tmo", bus.busy, 32'd0);
        check_segment("t2_tmo");

        // Back-to-back pair forms one frame
        send_good(8'h12);
        send_good(8'h34);
        idle(20);
        check("t3_frame_data", bus.frame_data, 32'h1234);
        check("t3_busy", bus.busy, 32'd0);
        check_segment("t3");

        // Short low glitch is a false start
        bus.rx_in = 1'b0;
        repeat (3) @(negedge clk);
        idle(50);
        check("t4_busy", bus.busy, 32'd0);
        check_segment("t4");

        // Bad stop bit with the line held low, then recovery
        send_byte(8'h55, 1'b0);
        model_bad();
        bus.rx_in = 1'b0;
        repeat (40) @(negedge clk);
        idle(20);
        check("t5_busy", bus.busy, 32'd0);
        check("t5_frame_kept", bus.frame_data, 32'h1234);
        check_segment("t5");
        send_good(8'hAB);
        send_good(8'hCD);
        idle(20);
        check("t5_frame_data", bus.frame_data, 32'hABCD);
        check_segment("t5b");

        // Inter-byte timeout fires exactly TMO_CYC cycles after byte_valid
        send_good(8'h77);
        idle_long(170);
        check("t6_tmo_dist", fe_cyc - bv_cyc, TMO_CYC);
        check("t6_byte_kept", bus.byte_data, 32'h77);
        check_segment("t6");
        send_good(8'h01);
        send_good(8'h02);
        idle(20);
        check("t6_frame_data", bus.frame_data, 32'h0102);
        check_segment("t6b");

        // Reset in the middle of the second byte of a frame
        send_good(8'h11);
        idle(5);
        part = 8'h3C;
        bus.rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.rx_in = part[i];
            repeat (CPB) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("t7_rst_byte_data", bus.byte_data, 32'h0);
        check("t7_rst_frame_data", bus.frame_data, 32'h0);
        check("t7_rst_pulses", {29'b0, bus.byte_valid, bus.frame_valid, bus.frame_err}, 32'd0);
        check("t7_rst_busy", bus.busy, 32'd0);
        model_reset();
        bus.rx_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        send_good(8'h9A);
        send_good(8'hBC);
        idle(20);
        check("t7_frame_data", bus.frame_data, 32'h9ABC);
        check_segment("t7");

        // Random traffic: good bytes, bad stop bits, glitches, short and long gaps
        for (int it = 0; it < 40; it++) begin
            k = int'($urandom_range(0, 9));
            b = 8'($urandom);
            if (k < 7) begin
                send_good(b);
            end else if (k < 9) begin
                send_byte(b, 1'b0);
                model_bad();
                bus.rx_in = 1'b0;
                repeat ($urandom_range(1, 30)) @(negedge clk);
            end else if (m_cnt == 0) begin
                bus.rx_in = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            if ($urandom_range(0, 4) == 0)
                idle_long(300);
            else
                idle(int'($urandom_range(4, 40)));
        end
        idle_long(300);
        check("rand_busy", bus.busy, 32'd0);
        check_segment("rand");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
